// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one sram-like memory port between the fetch master (I) and the
//   data master (D) using a req/addr_ok/data_ok split handshake. The owner of
//   every accepted transaction is queued so that in-order responses are
//   routed back to the master that issued them.
//
//   Optional build macro ARB_RR_EN: round-robin between I and D on contested
//   grants. When undefined, D has fixed priority over I.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   i_req/i_addr                  fetch request (held until i_addr_ok)
//   i_addr_ok/i_data_ok/i_rdata   fetch handshake back to the fetch stage
//   d_req/d_wr/d_size/d_wstrb/d_addr/d_wdata   data request (held until d_addr_ok)
//   d_addr_ok/d_data_ok/d_rdata   data handshake back to the memory stage
//   m_req..m_wdata                muxed request towards the slave
//   m_addr_ok/m_data_ok/m_rdata   slave handshake (responses in issue order)
//   proto_err                     sticky: data_ok seen with nothing outstanding
module sram_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_OUTS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [1:0]          d_size,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_wr,
  output logic [1:0]          m_size,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                proto_err
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTS);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {StIdle, StLockI, StLockD} state_e;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [MAX_OUTS-1:0] r_owner;  // 1 = D, 0 = I
  logic                r_proto_err;

  logic w_full, w_empty, w_pick_d, w_gnt_i, w_gnt_d, w_push, w_pop, w_head_d;

  assign w_full  = (r_count == CNT_W'(MAX_OUTS));
  assign w_empty = (r_count == '0);

`ifdef ARB_RR_EN
  logic r_last_d;
  // Contested grant goes to whoever did not win the last accept.
  assign w_pick_d = d_req & (~i_req | ~r_last_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (w_push) begin
      r_last_d <= w_gnt_d;
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  always_comb begin
    w_gnt_i     = 1'b0;
    w_gnt_d     = 1'b0;
    w_state_nxt = StIdle;
    unique case (r_state)
      StIdle: begin
        if (!w_full) begin
          if (w_pick_d) begin
            w_gnt_d = 1'b1;
          end else if (i_req) begin
            w_gnt_i = 1'b1;
          end
        end
      end
      StLockI: w_gnt_i = 1'b1;
      StLockD: w_gnt_d = 1'b1;
      default: ;
    endcase
    // Freeze the grant until the slave takes the address.
    if (w_gnt_i && !m_addr_ok) begin
      w_state_nxt = StLockI;
    end else if (w_gnt_d && !m_addr_ok) begin
      w_state_nxt = StLockD;
    end
  end

  assign m_req   = w_gnt_i | w_gnt_d;
  assign m_wr    = w_gnt_d & d_wr;
  assign m_size  = w_gnt_d ? d_size : 2'd2;
  assign m_wstrb = w_gnt_d ? d_wstrb : '0;
  assign m_addr  = w_gnt_d ? d_addr : i_addr;
  assign m_wdata = w_gnt_d ? d_wdata : '0;

  assign w_push = m_req & m_addr_ok;
  assign w_pop  = m_data_ok & ~w_empty;

  assign i_addr_ok = w_gnt_i & m_addr_ok;
  assign d_addr_ok = w_gnt_d & m_addr_ok;

  assign w_head_d  = r_owner[r_rd_ptr];
  assign i_data_ok = w_pop & ~w_head_d;
  assign d_data_ok = w_pop & w_head_d;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign proto_err = r_proto_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_owner     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_owner[r_wr_ptr] <= w_gnt_d;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (m_data_ok && w_empty) begin
        r_proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int MAX    = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_addr_ok, i_data_ok;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req = 1'b0, d_wr = 1'b0;
  logic [1:0]        d_size = 2'd2;
  logic [STRB_W-1:0] d_wstrb = '0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_addr_ok, d_data_ok;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req, m_wr;
  logic [1:0]        m_size;
  logic [STRB_W-1:0] m_wstrb;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok = 1'b0, m_data_ok = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              proto_err;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTS(MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .proto_err(proto_err)
  );

  // Reference model: queue of owners (0=I, 1=D), pending locked grant, last winner.
  int q[$];
  int lock_g = -1;
  int last_w = 0;
  bit perr   = 1'b0;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit e_i_aok, e_d_aok;
  bit i_pend = 1'b0, d_pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete(); lock_g = -1; last_w = 0; perr = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
  endtask

  // Compare all outputs at the falling edge, then advance the model by one cycle.
  task automatic sample();
    int g;
    bit pop_v, head_d;
    @(negedge clk);
    if (lock_g >= 0) g = lock_g;
    else if (q.size() >= MAX) g = -1;
    else if (d_req && i_req) g = RR ? ((last_w == 1) ? 0 : 1) : 1;
    else if (d_req) g = 1;
    else if (i_req) g = 0;
    else g = -1;
    e_i_aok = (g == 0) && m_addr_ok;
    e_d_aok = (g == 1) && m_addr_ok;
    pop_v   = m_data_ok && (q.size() > 0);
    head_d  = (q.size() > 0) ? (q[0] == 1) : 1'b0;
    chk("m_req", m_req, g >= 0);
    if (g == 1) begin
      chk("m_addr_d", m_addr, d_addr);
      chk("m_wr_d", m_wr, d_wr);
      chk("m_size_d", m_size, d_size);
      chk("m_wstrb_d", m_wstrb, d_wstrb);
      chk("m_wdata_d", m_wdata, d_wdata);
    end else if (g == 0) begin
      chk("m_addr_i", m_addr, i_addr);
      chk("m_wr_i", m_wr, 0);
      chk("m_size_i", m_size, 2);
      chk("m_wstrb_i", m_wstrb, 0);
    end
    chk("i_addr_ok", i_addr_ok, e_i_aok);
    chk("d_addr_ok", d_addr_ok, e_d_aok);
    chk("i_data_ok", i_data_ok, pop_v && !head_d);
    chk("d_data_ok", d_data_ok, pop_v && head_d);
    chk("i_rdata", i_rdata, m_rdata);
    chk("d_rdata", d_rdata, m_rdata);
    chk("proto_err", proto_err, perr);
    if (m_data_ok) begin
      if (q.size() > 0) void'(q.pop_front());
      else perr = 1'b1;
    end
    if (g >= 0 && m_addr_ok) begin
      q.push_back(g);
      last_w = g;
      lock_g = -1;
    end else begin
      lock_g = g;
    end
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();
    sample(); chk("rst_m_req", m_req, 0); chk("rst_proto_err", proto_err, 0); adv();

    // Single load with 3-cycle slave latency.
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_wstrb = '0; d_addr = 32'h1c00_0010;
    m_addr_ok = 1'b1;
    sample(); chk("t1_d_addr_ok", d_addr_ok, 1); chk("t1_m_addr", m_addr, 32'h1c00_0010); adv();
    d_req = 1'b0; m_addr_ok = 1'b0;
    sample(); adv();
    sample(); adv();
    m_data_ok = 1'b1; m_rdata = 32'hdead_beef;
    sample();
    chk("t1_d_data_ok", d_data_ok, 1); chk("t1_i_data_ok", i_data_ok, 0);
    chk("t1_d_rdata", d_rdata, 32'hdead_beef);
    adv();
    m_data_ok = 1'b0;

    // Both request from idle: D first, I next, responses routed in order.
    do_reset();
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200; m_addr_ok = 1'b1;
    sample(); chk("t2_d_first", d_addr_ok, 1); chk("t2_i_wait", i_addr_ok, 0); adv();
    d_req = 1'b0;
    sample(); chk("t2_i_next", i_addr_ok, 1); adv();
    i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h1;
    sample(); chk("t2_rsp0_d", d_data_ok, 1); chk("t2_rsp0_i", i_data_ok, 0); adv();
    m_rdata = 32'h2;
    sample(); chk("t2_rsp1_i", i_data_ok, 1); chk("t2_rsp1_d", d_data_ok, 0); adv();
    m_data_ok = 1'b0;

    // Grant frozen on I while addr_ok is withheld; D arrives mid-lock.
    do_reset();
    i_req = 1'b1; i_addr = 32'h3000; m_addr_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h4000; d_wdata = 32'h55aa; d_wstrb = 4'hf;
      end
      sample();
      chk("t3_lock_addr", m_addr, 32'h3000); chk("t3_lock_wr", m_wr, 0);
      adv();
    end
    m_addr_ok = 1'b1;
    sample(); chk("t3_i_acc", i_addr_ok, 1); adv();
    i_req = 1'b0;
    sample(); chk("t3_d_acc", d_addr_ok, 1); chk("t3_d_addr", m_addr, 32'h4000); adv();
    d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    sample(); adv(); sample(); adv();
    m_data_ok = 1'b0;

    // Outstanding limit.
    do_reset();
    d_req = 1'b1; d_wr = 1'b0; m_addr_ok = 1'b1;
    sample(); adv(); sample(); adv();
    sample(); chk("t4_full_m_req", m_req, 0); chk("t4_full_aok", d_addr_ok, 0); adv();
    m_data_ok = 1'b1;
    sample(); chk("t4_full_pop_m_req", m_req, 0); adv();
    sample(); chk("t4_push_pop_aok", d_addr_ok, 1); adv();
    m_data_ok = 1'b0;
    sample(); chk("t4_refill_aok", d_addr_ok, 1); adv();
    sample(); chk("t4_full_again", m_req, 0); adv();
    d_req = 1'b0; m_data_ok = 1'b1;
    sample(); adv(); sample(); adv();
    m_data_ok = 1'b0;

    // Stray data_ok with nothing outstanding.
    do_reset();
    m_data_ok = 1'b1;
    sample(); chk("t5_no_i_dok", i_data_ok, 0); chk("t5_no_d_dok", d_data_ok, 0); adv();
    m_data_ok = 1'b0;
    sample(); chk("t5_perr_set", proto_err, 1); adv();
    for (int k = 0; k < 3; k++) begin sample(); adv(); end
    sample(); chk("t5_perr_held", proto_err, 1); adv();
    do_reset();
    sample(); chk("t5_perr_clr", proto_err, 0); adv();

    // Continuous contention with instant accept.
    do_reset();
    i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0; m_addr_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m_data_ok = (q.size() > 0);
      sample();
      chk("t6_d_win", d_addr_ok, RR ? (k % 2 == 0) : 1);
      chk("t6_i_win", i_addr_ok, RR ? (k % 2 == 1) : 0);
      adv();
    end
    i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end
      if (!i_pend) begin
        i_req = ($urandom_range(2) == 0);
        if (i_req) begin
          i_addr = $urandom; i_pend = 1'b1;
        end
      end
      if (!d_pend) begin
        d_req = ($urandom_range(2) == 0);
        if (d_req) begin
          d_wr = $urandom_range(1) == 1; d_size = 2'($urandom_range(2));
          d_wstrb = STRB_W'($urandom); d_addr = $urandom; d_wdata = $urandom;
          d_pend = 1'b1;
        end
      end
      m_addr_ok = ($urandom_range(1) == 1);
      m_data_ok = (q.size() > 0) ? ($urandom_range(2) == 0) : ($urandom_range(49) == 0);
      m_rdata = $urandom;
      sample();
      if (e_i_aok) i_pend = 1'b0;
      if (e_d_aok) d_pend = 1'b0;
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
